// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo: receive-only PS/2 keyboard front end.
// Synchronises PS2_CLK/PS2_DAT, deframes 11-bit frames, decodes scancode
// set 2 prefixes (E0, F0, E1) into make/break events and buffers them in a
// first-word-fall-through FIFO drained by a valid/ready handshake.
// Optional build macro: PS2_PARITY_CHECK_EN (enables odd-parity checking).
module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DAT,
  input  logic                        clear,
  input  logic                        key_ready,
  output logic                        key_valid,
  output logic [7:0]                  key_code,
  output logic                        key_make,
  output logic                        key_ext,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    DEC_NORMAL,
    DEC_SKIP
  } dec_state_e;

  // ---------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // ---------------------------------------------------------------------
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  // Two-flop synchronisers plus one delayed copy of the synced clock.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             byte_done_q, byte_done_d;
  logic             rx_err;
  logic             parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  assign parity_ok = ^{parity_q, shift_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Receiver next state: advances on synced PS2_CLK falls, aborts on timeout.
  always_comb begin
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_cnt_d   = tmo_cnt_q;
    byte_done_d = 1'b0;
    rx_err      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d    = parity_q;
`endif
    if (clear) begin
      rx_state_d = RX_IDLE;
      bit_cnt_d  = '0;
      tmo_cnt_d  = '0;
    end else if (fall) begin
      tmo_cnt_d = '0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!dat_sync_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = '0;
          end else begin
            rx_err = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dat_sync_q;
`endif
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          rx_state_d = RX_IDLE;
          if (dat_sync_q && parity_ok) begin
            byte_done_d = 1'b1;
          end else begin
            rx_err = 1'b1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else if (rx_state_q != RX_IDLE) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        rx_state_d = RX_IDLE;
        tmo_cnt_d  = '0;
        rx_err     = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_cnt_q   <= '0;
      byte_done_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_cnt_q   <= tmo_cnt_d;
      byte_done_q <= byte_done_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Scancode decoder (shift_q holds the completed byte while byte_done_q)
  // ---------------------------------------------------------------------
  dec_state_e dec_state_q, dec_state_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_cnt_q, skip_cnt_d;
  logic       push_q, push_d;
  logic [9:0] push_data_q, push_data_d;

  // Decoder next state: prefix flags, Pause skip sequence, event push.
  always_comb begin
    dec_state_d = dec_state_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    skip_cnt_d  = skip_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (clear) begin
      dec_state_d = DEC_NORMAL;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      skip_cnt_d  = '0;
    end else if (byte_done_q) begin
      case (dec_state_q)
        DEC_NORMAL: begin
          case (shift_q)
            8'hF0: brk_d = 1'b1;
            8'hE0: ext_d = 1'b1;
            8'hE1: begin
              dec_state_d = DEC_SKIP;
              skip_cnt_d  = 3'd7;
            end
            8'h00, 8'hFF: ;
            default: begin
              push_d      = 1'b1;
              push_data_d = {ext_q, ~brk_q, shift_q};
              ext_d       = 1'b0;
              brk_d       = 1'b0;
            end
          endcase
        end
        DEC_SKIP: begin
          if (skip_cnt_q == 3'd1) begin
            push_d      = 1'b1;
            push_data_d = {1'b0, 1'b1, 8'hE1};
            dec_state_d = DEC_NORMAL;
            skip_cnt_d  = '0;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else begin
            skip_cnt_d = skip_cnt_q - 3'd1;
          end
        end
        default: dec_state_d = DEC_NORMAL;
      endcase
    end
  end

  // Decoder state registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      dec_state_q <= DEC_NORMAL;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_cnt_q  <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      dec_state_q <= dec_state_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_cnt_q  <= skip_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO and sticky flags
  // ---------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          frame_error_q, frame_error_d;
  logic          full, pop, wr_en;
  logic [9:0]    head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = key_valid & key_ready & ~clear;
  // A push into a full FIFO still lands when a pop frees the head slot.
  assign wr_en = push_q & (~full | pop) & ~clear;

  // FIFO pointer/count update and sticky error flags.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    frame_error_d = frame_error_q;
    if (clear) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      overflow_d    = 1'b0;
      frame_error_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_q && full && !pop) overflow_d = 1'b1;
      if (rx_err) frame_error_d = 1'b1;
    end
  end

  // FIFO control and flag registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Event storage; contents are don't-care until written, outputs are gated.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign head        = mem_q[rd_ptr_q];
  assign key_valid   = (count_q != '0);
  assign key_code    = key_valid ? head[7:0] : 8'h00;
  assign key_make    = key_valid & head[8];
  assign key_ext     = key_valid & head[9];
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Testbench for ps2_key_event_fifo: directed PS/2 frames, event-queue model,
// per-cycle comparison of outputs plus literal spot checks.
module tb_ps2_key_event_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 300;
  localparam int H     = 6;   // PS/2 half-period in system clocks

  logic       CLOCK_50  = 1'b0;
  logic       resetn    = 1'b0;
  logic       PS2_CLK   = 1'b1;
  logic       PS2_DAT   = 1'b1;
  logic       clear     = 1'b0;
  logic       key_ready = 1'b0;
  logic       key_valid, key_make, key_ext, overflow, frame_error;
  logic [7:0] key_code;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state: queue of {ext, make, code} events plus flags.
  logic [9:0] mq[$];
  bit         m_ovf, m_ferr, m_ext, m_brk;
  int         m_skip;
  logic [9:0] cmp_head;
  logic [9:0] tmp_ev;

  ps2_key_event_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .clear       (clear),
    .key_ready   (key_ready),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_make    (key_make),
    .key_ext     (key_ext),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .frame_error (frame_error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
  endtask

  task automatic model_push(input logic [9:0] ev);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(ev);
  endtask

  // Scancode set 2 interpretation of one received byte.
  task automatic model_byte(input logic [7:0] b);
    if (m_skip != 0) begin
      m_skip--;
      if (m_skip == 0) begin
        model_push({1'b0, 1'b1, 8'hE1});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_skip = 0;
    end else begin
      model_push({m_ext, ~m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge CLOCK_50) begin
    #1;
    if (chk_en) begin
      check("fifo_count", 32'(fifo_count), mq.size());
      check("key_valid", 32'(key_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        cmp_head = mq[0];
        check("key_code", 32'(key_code), 32'(cmp_head[7:0]));
        check("key_make", 32'(key_make), 32'(cmp_head[8]));
        check("key_ext", 32'(key_ext), 32'(cmp_head[9]));
      end
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("frame_error", 32'(frame_error), 32'(m_ferr));
    end
  end

  task automatic ps2_bit(input logic v);
    @(negedge CLOCK_50);
    PS2_DAT = v;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
  endtask

  // Start, 8 data bits LSB first, odd parity (optionally corrupted).
  task automatic send_front(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
  endtask

  task automatic send_key(input logic [7:0] b);
    chk_en = 1'b0;
    send_front(b, 1'b0);
    ps2_bit(1'b1);
    repeat (8) @(negedge CLOCK_50);
    model_byte(b);
    chk_en = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge CLOCK_50);
    key_ready = 1'b1;
    @(posedge CLOCK_50);
    if (mq.size() != 0) tmp_ev = mq.pop_front();
    @(negedge CLOCK_50);
    key_ready = 1'b0;
  endtask

  task automatic clear_all();
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(posedge CLOCK_50);
    model_reset();
    @(negedge CLOCK_50);
    clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(key_valid), 0);
    check({tag, "_code"}, 32'(key_code), 0);
    check({tag, "_make"}, 32'(key_make), 0);
    check({tag, "_ext"}, 32'(key_ext), 0);
    check({tag, "_count"}, 32'(fifo_count), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_ferr"}, 32'(frame_error), 0);
  endtask

  initial begin
    #3_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_values("reset");
    @(negedge CLOCK_50);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge CLOCK_50);

    // Pop on an empty FIFO is ignored.
    pop_one();

    // Frame 1C with latency measured from the raw stop-bit fall.
    chk_en = 1'b0;
    send_front(8'h1C, 1'b0);
    @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1 check("lat4_valid", 32'(key_valid), 0);
    @(posedge CLOCK_50);
    #1 check("lat5_valid", 32'(key_valid), 1);
    check("1c_code", 32'(key_code), 32'h1C);
    check("1c_make", 32'(key_make), 1);
    check("1c_ext", 32'(key_ext), 0);
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    model_byte(8'h1C);
    chk_en = 1'b1;
    pop_one();

    // Extended break: E0 F0 75.
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    #1 check("e075_count", 32'(fifo_count), 1);
    check("e075_code", 32'(key_code), 32'h75);
    check("e075_make", 32'(key_make), 0);
    check("e075_ext", 32'(key_ext), 1);
    pop_one();

    // Discarded 00 keeps the pending extended flag.
    send_key(8'hE0);
    send_key(8'h00);
    send_key(8'h6B);
    pop_one();

    // Pause sequence yields one event.
    send_key(8'hE1); send_key(8'h14); send_key(8'h77); send_key(8'hE1);
    send_key(8'hF0); send_key(8'h14); send_key(8'hF0);
    #1 check("pause_none_yet", 32'(fifo_count), 0);
    send_key(8'h77);
    #1 check("pause_count", 32'(fifo_count), 1);
    check("pause_code", 32'(key_code), 32'hE1);
    check("pause_make", 32'(key_make), 1);
    check("pause_ext", 32'(key_ext), 0);
    pop_one();

    // 17 make codes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) send_key(8'h10 + 8'(i));
    #1 check("ovf_count", 32'(fifo_count), 16);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", 32'(key_code), 32'h10);
    clear_all();
    #1 check("clr_count", 32'(fifo_count), 0);
    check("clr_ovf", 32'(overflow), 0);

    // Push and pop together when full.
    for (int i = 0; i < 16; i++) send_key(8'h10 + 8'(i));
    chk_en = 1'b0;
    send_front(8'h30, 1'b0);
    @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    key_ready = 1'b1;
    @(posedge CLOCK_50);
    tmp_ev = mq.pop_front();
    model_byte(8'h30);
    @(negedge CLOCK_50);
    key_ready = 1'b0;
    repeat (H) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    chk_en = 1'b1;
    #1 check("pp_count", 32'(fifo_count), 16);
    check("pp_ovf", 32'(overflow), 0);
    check("pp_head", 32'(key_code), 32'h11);
    clear_all();

    // Corrupted parity on 1C.
    chk_en = 1'b0;
    send_front(8'h1C, 1'b1);
    ps2_bit(1'b1);
    repeat (8) @(negedge CLOCK_50);
`ifdef PS2_PARITY_CHECK_EN
    m_ferr = 1'b1;
    #1 check("par_ferr", 32'(frame_error), 1);
    check("par_count", 32'(fifo_count), 0);
`else
    model_byte(8'h1C);
    #1 check("par_ferr", 32'(frame_error), 0);
    check("par_count", 32'(fifo_count), 1);
`endif
    chk_en = 1'b1;
    clear_all();

    // Clock stopped after 4 bits: timeout aborts the partial frame.
    chk_en = 1'b0;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TMO - 40) @(negedge CLOCK_50);
    check("tmo_early_ferr", 32'(frame_error), 0);
    repeat (60) @(negedge CLOCK_50);
    check("tmo_ferr", 32'(frame_error), 1);
    m_ferr = 1'b1;
    chk_en = 1'b1;
    send_key(8'h29);
    #1 check("tmo_next_code", 32'(key_code), 32'h29);
    check("tmo_next_make", 32'(key_make), 1);
    check("tmo_next_count", 32'(fifo_count), 1);

    // resetn pulsed mid-frame with events and a sticky flag present.
    send_key(8'h1A);
    chk_en = 1'b0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge CLOCK_50);
    resetn = 1'b0;
    model_reset();
    #1 check_reset_values("midrst");
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check_reset_values("postrst");
    chk_en = 1'b1;
    send_key(8'h1B);
    #1 check("postrst_code", 32'(key_code), 32'h1B);
    pop_one();
    repeat (4) @(negedge CLOCK_50);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
# ps2_key_event_fifo

Receive-only PS/2 keyboard front end for the music-source design: samples PS2_CLK/PS2_DAT directly, deframes 11-bit PS/2 frames, and decodes scancode set 2 prefixes (E0, F0, E1) into make/break key events. Events are buffered in a parametrised FIFO and drained through a valid/ready handshake. It is the successor to the single-byte, break-only key latch: it reports both make and break, carries an extended-key flag, buffers many events, and flags framing and overflow errors.

## Interface
- FIFO_DEPTH, 16, event FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 50000, CLOCK_50 cycles without a PS2_CLK falling edge before a partial frame is aborted (1 ms at 50 MHz)
- CLOCK_50  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous active-low reset
- PS2_CLK  in  1  raw PS/2 clock, asynchronous, idle high
- PS2_DAT  in  1  raw PS/2 data, asynchronous, idle high
- clear  in  1  synchronous flush of FIFO, decoder, receiver and sticky flags
- key_ready  in  1  consumer accepts head event
- key_valid  out  1  FIFO non-empty
- key_code  out  8  head event scancode
- key_make  out  1  1 = press, 0 = release
- key_ext  out  1  1 = E0-prefixed key
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: event dropped, FIFO full
- frame_error  out  1  sticky: bad start/stop/parity or timeout

## Operation
- Sync: PS2_CLK and PS2_DAT each pass a 2-flop synchroniser (reset to 1); a falling edge is synced clock 1 → 0 vs the previous cycle.
- Receiver FSM, advancing only on synced falling edges: IDLE (DAT=0 → DATA; DAT=1 → error, stay IDLE) → DATA (8 bits, LSB first, 3-bit counter) → PARITY (sample) → STOP (DAT=1 and parity OK → byte_done pulse; else error) → IDLE.
- Timeout: a counter clears on each falling edge and counts in non-IDLE states; reaching TIMEOUT_CYCLES → IDLE, frame_error set, partial byte discarded.
- Decoder, on each byte_done: F0 → brk=1; E0 → ext=1; E1 → SKIP, 3-bit counter =7; 00/FF → discarded, flags kept; any other byte → push {ext, make=!brk, code}, then clear ext and brk.
- SKIP: the next 7 bytes are discarded; on the 7th, push {ext=0, make=1, code=E1} (Pause) and return to NORMAL.
- FIFO: circular buffer of 10-bit entries, first-word-fall-through; key_* show the head whenever key_valid=1.
- Pop when key_valid & key_ready. Push when full and no pop → event dropped, overflow set. Push and pop together when full → both happen, count unchanged. Pop when empty → ignored.
- clear (one cycle): count=0, pointers=0, decoder NORMAL with flags 0, receiver IDLE, timeout counter 0, overflow=0, frame_error=0. clear outranks a push or pop in the same cycle.
- Sticky flags stay set until clear or reset.

## Timing
- Reset values: key_valid=0, key_code=00, key_make=0, key_ext=0, fifo_count=0, overflow=0, frame_error=0; all FSMs in IDLE/NORMAL; synchroniser flops=1.
- Falling-edge detect fires 3 cycles after the raw PS2_CLK falls.
- byte_done pulses the cycle after the edge that samples the stop bit. The push registers 1 cycle later. key_valid rises the cycle after that if the FIFO was empty.
- Pop takes effect at the accepting edge; the next head or key_valid=0 shows the following cycle.
- resetn asserted mid-frame or mid-sequence: immediate return to the reset values; a partial frame is never pushed.
- fifo_count == FIFO_DEPTH means full; wrap-around uses the natural pointer overflow, since the depth is a power of two.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is checked; a mismatch drops the byte and sets frame_error.
- Not defined: the parity bit is sampled but ignored; only start/stop/timeout set frame_error.

## Test plan
- Frame 1C, good parity → one event {code=1C, make=1, ext=0}; key_valid rises 5 cycles after the raw stop-bit falling edge.
- Bytes E0 F0 75 → one event {75, make=0, ext=1}; no event for the prefixes.
- Sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {E1, make=1, ext=0}.
- key_ready=0, 17 make codes with FIFO_DEPTH=16 → fifo_count=16, overflow=1, head is the first code; push+pop together when full → count stays 16.
- Parity flipped on 1C → no event, frame_error=1 with PS2_PARITY_CHECK_EN; event pushed and frame_error=0 without it.
- PS2_CLK stopped after 4 bits → frame_error=1 after TIMEOUT_CYCLES; the next good frame 29 decodes correctly. resetn pulsed mid-frame → all outputs return to reset values.
